// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-sequencer state encoding for the parametrised register file
package regfile_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;
  localparam int NRD_D = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} clr_state_e;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: clear-sweep FSM stepping a pointer over every writable entry, one per cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  clr_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: if (clr_req) begin
        state_d = SWEEP;
        ptr_d = FIRST;
      end
      // the last entry ends the sweep with the pointer parked, so it never wraps
      SWEEP: if (&ptr_q) state_d = DONE;
             else ptr_d = ptr_q + ADDR_W'(1);
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  assign clr_we = state_q == SWEEP;
  assign clr_addr = ptr_q;
  assign clr_busy = state_q == SWEEP;
  assign clr_done = state_q == DONE;
endmodule

// File: rtl/regfile_param_bypass.sv
// regfile_param_bypass: parametrised register file with optional zero register, write bypass and clear sweep
module regfile_param_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int NRD = NRD_D,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_W-1:0]     Write_register,
  input  logic [DATA_W-1:0]     Write_data,
  input  logic [NRD*ADDR_W-1:0] Read_register,
  output logic [NRD*DATA_W-1:0] Read_data,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic clr_we, wr_ok;
  logic [ADDR_W-1:0] clr_addr;
  regfile_clear_seq #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_clr (
    .clk(clk),
    .reset(reset),
    .clr_req(clr_req),
    .clr_we(clr_we),
    .clr_addr(clr_addr),
    .clr_busy(clr_busy),
    .clr_done(clr_done)
  );
  assign wr_ok = RegWrite && !((ZERO_REG != 0) && Write_register == '0);
  // the port write is applied after the sweep clear so it wins on a collision
  always_comb begin
    mem_d = mem_q;
    if (clr_we) mem_d[clr_addr] = '0;
    if (wr_ok) mem_d[Write_register] = Write_data;
  end
  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = Read_register[k*ADDR_W +: ADDR_W];
    assign Read_data[k*DATA_W +: DATA_W] =
      ((ZERO_REG != 0) && ra == '0) ? '0 :
      ((BYPASS != 0) && wr_ok && ra == Write_register) ? Write_data : mem_q[ra];
  end
endmodule

// File: tb/tb_regfile_param_bypass.sv
// tb_regfile_param_bypass: directed checks of the default file and a small NRD=4, no-zero, no-bypass variant
module tb_regfile_param_bypass;
  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;
  logic a_we, a_clr, a_busy, a_done;
  logic [4:0] a_wa;
  logic [31:0] a_wd;
  logic [9:0] a_rr;
  logic [63:0] a_rd;
  logic b_we, b_clr, b_busy, b_done;
  logic [2:0] b_wa;
  logic [31:0] b_wd;
  logic [11:0] b_rr;
  logic [127:0] b_rd;
  int n_chk = 0, n_pass = 0;
  int nb, nd;
  regfile_param_bypass dut_a (
    .clk(clk), .reset(reset), .RegWrite(a_we), .Write_register(a_wa), .Write_data(a_wd),
    .Read_register(a_rr), .Read_data(a_rd), .clr_req(a_clr), .clr_busy(a_busy), .clr_done(a_done)
  );
  regfile_param_bypass #(.DATA_W(32), .ADDR_W(3), .NRD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .RegWrite(b_we), .Write_register(b_wa), .Write_data(b_wd),
    .Read_register(b_rr), .Read_data(b_rd), .clr_req(b_clr), .clr_busy(b_busy), .clr_done(b_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic check_all_zero(input string tag);
    logic [31:0] acc = 0;
    for (int i = 0; i < 32; i++) begin
      a_rr = {5'd0, 5'(i)};
      #1 acc |= a_rd[31:0];
    end
    check(tag, acc, 32'h0);
  endtask
  task automatic run_sweep(input bit collide, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    @(negedge clk) a_clr = 1;
    @(negedge clk) a_clr = 0;
    for (int j = 0; j < 40; j++) begin
      #1;
      if (a_busy) busy_n++;
      if (a_done) done_n++;
      a_clr = (j == 10);
      a_we = 0;
      if (collide && j == 2) begin a_we = 1; a_wa = 20; a_wd = 32'h77; end
      if (collide && j == 11) begin
        a_we = 1; a_wa = 12; a_wd = 32'h55; a_rr = {5'd0, 5'd12};
        #1 check("sweep_bypass", a_rd[31:0], 32'h55);
      end
      if (collide && j == 14) begin a_we = 1; a_wa = 3; a_wd = 32'h66; end
      @(negedge clk);
    end
    a_we = 0;
    a_clr = 0;
  endtask
  initial begin
    reset = 1;
    {a_we, a_clr, a_wa, a_wd, a_rr} = '0;
    {b_we, b_clr, b_wa, b_wd, b_rr} = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    a_rr = {5'd5, 5'd5};
    #1;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_reg5", a_rd[31:0], 0);
    @(negedge clk) begin a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF; end
    @(negedge clk) a_we = 0;
    #1;
    check("rd5_p0", a_rd[31:0], 32'hDEADBEEF);
    check("rd5_p1", a_rd[63:32], 32'hDEADBEEF);
    a_we = 1; a_wa = 0; a_wd = 32'h1234; a_rr = {5'd0, 5'd0};
    #1 check("zero_byp", a_rd[31:0], 0);
    @(negedge clk) a_we = 0;
    #1 check("zero_reg", a_rd[63:32], 0);
    a_we = 1; a_wa = 7; a_wd = 32'hA5A5A5A5; a_rr = {5'd5, 5'd7};
    b_we = 1; b_wa = 7; b_wd = 32'hA5A5A5A5; b_rr = {9'd0, 3'd7};
    #1;
    check("byp_p0", a_rd[31:0], 32'hA5A5A5A5);
    check("byp_p1", a_rd[63:32], 32'hDEADBEEF);
    check("nobyp_old", b_rd[31:0], 0);
    @(negedge clk) begin a_we = 0; b_we = 0; end
    #1 check("nobyp_new", b_rd[31:0], 32'hA5A5A5A5);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk) begin a_we = 1; a_wa = 5'(i); a_wd = 32'(i); end
    end
    @(negedge clk) a_we = 0;
    a_rr = {5'd7, 5'd31};
    #1;
    check("fill31", a_rd[31:0], 31);
    check("fill7", a_rd[63:32], 7);
    run_sweep(0, nb, nd);
    check("sweep_busy", 32'(nb), 31);
    check("sweep_done", 32'(nd), 1);
    check_all_zero("sweep_zero");
    run_sweep(1, nb, nd);
    check("coll_busy", 32'(nb), 31);
    a_rr = {5'd3, 5'd12};
    #1;
    check("coll_r12", a_rd[31:0], 32'h55);
    check("coll_r3", a_rd[63:32], 32'h66);
    a_rr = {5'd0, 5'd20};
    #1 check("coll_r20", a_rd[31:0], 0);
    @(negedge clk) a_clr = 1;
    @(negedge clk) a_clr = 0;
    repeat (15) @(negedge clk);
    #1 check("mid_busy", 32'(a_busy), 1);
    reset = 1;
    @(negedge clk) reset = 0;
    #1 check("abort_busy", 32'(a_busy), 0);
    nd = 0;
    for (int j = 0; j < 5; j++) begin
      if (a_done) nd++;
      @(negedge clk);
      #1;
    end
    check("abort_nodone", 32'(nd), 0);
    check_all_zero("abort_zero");
    @(negedge clk);
    run_sweep(0, nb, nd);
    check("restart_busy", 32'(nb), 31);
    check("restart_done", 32'(nd), 1);
    @(negedge clk) begin b_we = 1; b_wa = 0; b_wd = 32'hF; b_rr = '0; end
    @(negedge clk) b_we = 0;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("b_r0_p%0d", k), b_rd[k*32 +: 32], 32'hF);
    nb = 0;
    nd = 0;
    @(negedge clk) b_clr = 1;
    @(negedge clk) b_clr = 0;
    for (int j = 0; j < 20; j++) begin
      #1;
      if (b_busy) nb++;
      if (b_done) nd++;
      @(negedge clk);
    end
    check("b_busy", 32'(nb), 8);
    check("b_done", 32'(nd), 1);
    #1 check("b_r0_clr", b_rd[31:0], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
